// File: rtl/decode_stage_pkg.sv
// Shared definitions for the SCC decode stage: instruction field positions,
// ALU_OC / B_cond encodings and opcode-class helpers.
package decode_stage_pkg;

  localparam int REG_W   = 3;
  localparam int FL_MSB  = 31;
  localparam int FL_LSB  = 30;
  localparam int SPC_BIT = 29;
  localparam int SLD_MSB = 28;
  localparam int SLD_LSB = 25;
  localparam int OC_MSB  = 24;
  localparam int OC_LSB  = 22;
  localparam int RD_MSB  = 21;
  localparam int RD_LSB  = 19;
  localparam int BC_MSB  = 21;
  localparam int BC_LSB  = 18;
  localparam int RP_MSB  = 18;
  localparam int RP_LSB  = 16;
  localparam int R2_MSB  = 15;
  localparam int R2_LSB  = 13;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ALU_MOV = 3'b000,
    ALU_ADD = 3'b001,
    ALU_SUB = 3'b010,
    ALU_AND = 3'b011,
    ALU_OR  = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SHF = 3'b110,
    ALU_RSV = 3'b111
  } alu_oc_e;

  typedef enum logic [3:0] {
    BC_AL  = 4'h0,
    BC_EQ  = 4'h1,
    BC_NE  = 4'h2,
    BC_LT  = 4'h3,
    BC_GE  = 4'h4,
    BC_LTU = 4'h5,
    BC_GEU = 4'h6,
    BC_NV  = 4'hF
  } bcond_e;

  function automatic logic writesDest(input logic spc, input logic [1:0] fl, input logic [2:0] oc);
    if (spc) return (oc != ALU_MOV) && (oc != ALU_RSV);
    return (fl == 2'b00) && (oc <= ALU_XOR);
  endfunction

  // MOV is the only register-writing form that does not read op1.
  function automatic logic readsOp1(input logic spc, input logic [1:0] fl, input logic [2:0] oc);
    return writesDest(spc, fl, oc) && !(!spc && fl == 2'b00 && oc == ALU_MOV);
  endfunction

  function automatic logic readsOp2(input logic spc, input logic [1:0] fl, input logic [2:0] oc);
    return spc && fl[0] && (oc != ALU_SHF);
  endfunction

  function automatic logic isIllegalEnc(input logic spc, input logic [2:0] oc);
    return spc && ((oc == ALU_MOV) || (oc == ALU_RSV));
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback; a same-cycle set of the same bit takes priority.
module decode_scoreboard #(
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_i,
  input  logic [2:0]      setReg_i,
  input  logic            clr_i,
  input  logic [2:0]      clrReg_i,
  output logic [NREG-1:0] pending_o
);

  logic [NREG-1:0] pending_q, pending_d, setMask, clrMask;

  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (set_i) setMask[setReg_i] = 1'b1;
    if (clr_i) clrMask[clrReg_i] = 1'b1;
    pending_d = (pending_q & ~clrMask) | setMask;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/decode_stage.sv
// SCC decode stage: two-slot skid buffer in front of combinational field decode.
// Define DECODE_SCOREBOARD_EN to add the RAW/WAW hazard interlock.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int IW   = 32,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    First_LD,
  output logic          Special_encoding,
  output logic [3:0]    Second_LD,
  output logic [2:0]    ALU_OC,
  output logic [2:0]    dest_reg,
  output logic [3:0]    B_cond,
  output logic [2:0]    pointer_reg,
  output logic [2:0]    op2_reg,
  output logic [15:0]   immediate,
  output logic [15:0]   offset,
  output logic          illegal,
  input  logic          wb_valid,
  input  logic [2:0]    wb_reg
);

  logic          headValid_q, headValid_d, skidValid_q, skidValid_d, inReady_q;
  logic [IW-1:0] head_q, head_d, skid_q, skid_d;
  logic          accept, issue, headFree;

  assign accept   = in_valid & inReady_q;
  assign issue    = out_valid & out_ready;
  assign headFree = ~headValid_q | issue;
  assign in_ready = inReady_q;

  // in_ready tracks the skid slot, so an accept can never arrive with the skid full.
  always_comb begin
    headValid_d = headValid_q;
    head_d      = head_q;
    skidValid_d = skidValid_q;
    skid_d      = skid_q;
    if (flush) begin
      headValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (headFree) begin
      if (skidValid_q) begin
        headValid_d = 1'b1;
        head_d      = skid_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        headValid_d = 1'b1;
        head_d      = in_instr;
      end else begin
        headValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skid_d      = in_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      headValid_q <= 1'b0;
      skidValid_q <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      inReady_q   <= 1'b1;
    end else begin
      headValid_q <= headValid_d;
      skidValid_q <= skidValid_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      inReady_q   <= ~skidValid_d;
    end
  end

  assign First_LD         = head_q[FL_MSB:FL_LSB];
  assign Special_encoding = head_q[SPC_BIT];
  assign Second_LD        = head_q[SLD_MSB:SLD_LSB];
  assign ALU_OC           = head_q[OC_MSB:OC_LSB];
  assign dest_reg         = head_q[RD_MSB:RD_LSB];
  assign B_cond           = head_q[BC_MSB:BC_LSB];
  assign pointer_reg      = head_q[RP_MSB:RP_LSB];
  assign op2_reg          = head_q[R2_MSB:R2_LSB];
  assign immediate        = head_q[IMM_MSB:IMM_LSB];
  assign offset           = head_q[IMM_MSB:IMM_LSB];
  assign illegal          = headValid_q & isIllegalEnc(Special_encoding, ALU_OC);

`ifdef DECODE_SCOREBOARD_EN
  logic [NREG-1:0] pending;
  logic            sbSet, hazard;

  assign sbSet = issue & ~illegal & writesDest(Special_encoding, First_LD, ALU_OC);

  decode_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_i    (sbSet),
    .setReg_i (dest_reg),
    .clr_i    (wb_valid),
    .clrReg_i (wb_reg),
    .pending_o(pending)
  );

  // Hold the head back while any register it touches still has a write in flight.
  assign hazard = (readsOp1(Special_encoding, First_LD, ALU_OC) & pending[pointer_reg])
                | (readsOp2(Special_encoding, First_LD, ALU_OC) & pending[op2_reg])
                | (writesDest(Special_encoding, First_LD, ALU_OC) & pending[dest_reg]);

  assign out_valid = headValid_q & ~hazard;
`else
  logic unusedWb;
  assign unusedWb  = wb_valid ^ (^wb_reg);
  assign out_valid = headValid_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: skid buffer, field decode, flush, reset
// and (when DECODE_SCOREBOARD_EN is defined) the hazard interlock.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [1:0]  First_LD;
  logic        Special_encoding, illegal, wb_valid;
  logic [3:0]  Second_LD, B_cond;
  logic [2:0]  ALU_OC, dest_reg, pointer_reg, op2_reg, wb_reg;
  logic [15:0] immediate, offset;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  decode_stage #(.IW(32), .NREG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .First_LD(First_LD), .Special_encoding(Special_encoding), .Second_LD(Second_LD),
    .ALU_OC(ALU_OC), .dest_reg(dest_reg), .B_cond(B_cond), .pointer_reg(pointer_reg),
    .op2_reg(op2_reg), .immediate(immediate), .offset(offset), .illegal(illegal),
    .wb_valid(wb_valid), .wb_reg(wb_reg)
  );

  function automatic logic [31:0] mk(input logic [1:0] fl, input logic s, input logic [3:0] sl,
                                     input logic [2:0] oc, input logic [2:0] rd,
                                     input logic [2:0] rp, input logic [15:0] imm);
    return {fl, s, sl, oc, rd, rp, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_scoreboard();
    in_valid = 1'b0;
    for (int r = 0; r < 8; r++) begin
      wb_valid = 1'b1;
      wb_reg   = 3'(r);
      tick();
    end
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_reg = '0;
    tick(); tick();
    rst = 1'b0;
    nCompared++;
    if ({out_valid, in_ready, illegal} !== 3'b010) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 010", {out_valid, in_ready, illegal});
    end
    nCompared++;
    if ({First_LD, Special_encoding, Second_LD, ALU_OC, dest_reg, B_cond, pointer_reg, op2_reg,
         immediate, offset} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_fields: imm %h off %h oc %b rd %d expected all 0",
               immediate, offset, ALU_OC, dest_reg);
    end
  endtask

  task automatic test_add_imm();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h2040_0005;
    tick();
    in_valid = 1'b0;
    nCompared++;
    if (out_valid !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL add_latency: out_valid got %b expected 1", out_valid);
    end
    nCompared++;
    if ({Special_encoding, ALU_OC, dest_reg, First_LD, Second_LD, pointer_reg} !== {1'b1, 3'b001, 3'd0, 2'b00, 4'd0, 3'd0}) begin
      nMismatched++;
      $display("[TB] FAIL add_fields: S %b OC %b rd %d FL %b SL %h rp %d expected 1 001 0 00 0 0",
               Special_encoding, ALU_OC, dest_reg, First_LD, Second_LD, pointer_reg);
    end
    nCompared++;
    if ({immediate, offset} !== {16'h0005, 16'h0005}) begin
      nMismatched++; $display("[TB] FAIL add_imm: imm %h off %h expected 0005 0005", immediate, offset);
    end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL add_issued: out_valid got %b expected 0", out_valid);
    end
    drain_scoreboard();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_instr = mk(2'b10, 1'b0, 4'(i), 3'(i), 3'(i), 3'(7 - i), 16'h1000 + 16'(i));
      tick();
      nCompared++;
      if ({out_valid, in_ready, immediate} !== {1'b1, 1'b1, 16'h1000 + 16'(i)}) begin
        nMismatched++;
        $display("[TB] FAIL b2b_%0d: ov %b ir %b imm %h expected 1 1 %h", i, out_valid, in_ready,
                 immediate, 16'h1000 + 16'(i));
      end
      nCompared++;
      if ({B_cond, Second_LD} !== {3'(i), 1'b1, 4'(i)}) begin
        nMismatched++;
        $display("[TB] FAIL b2b_fields_%0d: bc %h sl %h expected %h %h", i, B_cond, Second_LD,
                 {3'(i), 1'b1}, 4'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL b2b_end: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hA0A0);
    tick();
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b11, 16'hA0A0}) begin
      nMismatched++; $display("[TB] FAIL bp_a: ov %b ir %b imm %h expected 1 1 a0a0", out_valid, in_ready, immediate);
    end
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hB0B0);
    tick();
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b10, 16'hA0A0}) begin
      nMismatched++; $display("[TB] FAIL bp_b: ov %b ir %b imm %h expected 1 0 a0a0", out_valid, in_ready, immediate);
    end
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hC0C0);
    tick();
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b10, 16'hA0A0}) begin
      nMismatched++; $display("[TB] FAIL bp_c_held: ov %b ir %b imm %h expected 1 0 a0a0", out_valid, in_ready, immediate);
    end
    out_ready = 1'b1;
    tick();
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b11, 16'hB0B0}) begin
      nMismatched++; $display("[TB] FAIL bp_release_b: ov %b ir %b imm %h expected 1 1 b0b0", out_valid, in_ready, immediate);
    end
    tick();
    in_valid = 1'b0;
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b11, 16'hC0C0}) begin
      nMismatched++; $display("[TB] FAIL bp_release_c: ov %b ir %b imm %h expected 1 1 c0c0", out_valid, in_ready, immediate);
    end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL bp_empty: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hD1D1);
    tick();
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hD2D2);
    tick();
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hD3D3);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    nCompared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL flush_state: ov %b ir %b expected 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL flush_no_skid: out_valid got %b imm %h expected 0", out_valid, immediate);
    end
    in_valid = 1'b1;
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hE5E5);
    tick();
    in_valid = 1'b0;
    nCompared++;
    if ({out_valid, immediate} !== {1'b1, 16'hE5E5}) begin
      nMismatched++; $display("[TB] FAIL flush_next: ov %b imm %h expected 1 e5e5", out_valid, immediate);
    end
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = mk(2'b00, 1'b1, 4'd0, 3'b111, 3'd4, 3'd0, 16'h0BAD);
    tick();
    in_valid = 1'b0;
    nCompared++;
    if ({out_valid, illegal, ALU_OC} !== {2'b11, 3'b111}) begin
      nMismatched++; $display("[TB] FAIL illegal_flag: ov %b ill %b oc %b expected 1 1 111", out_valid, illegal, ALU_OC);
    end
    tick();
    nCompared++;
    if ({out_valid, illegal} !== 2'b00) begin
      nMismatched++; $display("[TB] FAIL illegal_gone: ov %b ill %b expected 0 0", out_valid, illegal);
    end
    in_valid = 1'b1;
    in_instr = mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd4, 3'd4, 16'h0044);
    tick();
    in_valid = 1'b0;
    nCompared++;
    if ({out_valid, illegal} !== 2'b10) begin
      nMismatched++; $display("[TB] FAIL illegal_no_sb: ov %b ill %b expected 1 0", out_valid, illegal);
    end
    tick();
    drain_scoreboard();
  endtask

  task automatic hazard_case(input string name, input logic [31:0] wr, input logic [31:0] rd,
                             input logic [2:0] relReg, input logic [2:0] otherReg);
    out_ready = 1'b1; in_valid = 1'b1; in_instr = wr;
    tick();
    in_instr = rd;
    tick();
    in_valid = 1'b0;
    nCompared++;
    if ({out_valid, immediate} !== {!SB, rd[15:0]}) begin
      nMismatched++; $display("[TB] FAIL %s_stall: ov %b imm %h expected %b %h", name, out_valid, immediate, !SB, rd[15:0]);
    end
    wb_valid = 1'b1; wb_reg = otherReg;
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL %s_wrong_wb: out_valid got %b expected 0", name, out_valid);
    end
    wb_reg = relReg;
    tick();
    wb_valid = 1'b0;
    nCompared++;
    if (out_valid !== SB) begin
      nMismatched++; $display("[TB] FAIL %s_release: out_valid got %b expected %b", name, out_valid, SB);
    end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL %s_issued: out_valid got %b expected 0", name, out_valid);
    end
    drain_scoreboard();
  endtask

  task automatic test_hazard();
    hazard_case("raw_op1", mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd2, 3'd0, 16'h0002),
                mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd5, 3'd2, 16'h0005), 3'd2, 3'd3);
    hazard_case("raw_op2", mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd7, 3'd0, 16'h0007),
                mk(2'b01, 1'b1, 4'd0, 3'b011, 3'd1, 3'd0, 16'hE000), 3'd7, 3'd6);
    hazard_case("waw_mov", mk(2'b00, 1'b1, 4'd0, 3'b010, 3'd6, 3'd0, 16'h0006),
                mk(2'b00, 1'b0, 4'd0, 3'b000, 3'd6, 3'd0, 16'h0066), 3'd6, 3'd2);
  endtask

  task automatic test_wb_same_cycle();
    out_ready = 1'b1; in_valid = 1'b1;
    in_instr = mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd3, 3'd1, 16'h0033);
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b1; wb_reg = 3'd3;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1;
    in_instr = mk(2'b00, 1'b1, 4'd0, 3'b001, 3'd6, 3'd3, 16'h0066);
    tick();
    in_valid = 1'b0;
    nCompared++;
    if (out_valid !== !SB) begin
      nMismatched++; $display("[TB] FAIL wb_same_pending: out_valid got %b expected %b", out_valid, !SB);
    end
    wb_valid = 1'b1; wb_reg = 3'd3;
    tick();
    wb_valid = 1'b0;
    nCompared++;
    if (out_valid !== SB) begin
      nMismatched++; $display("[TB] FAIL wb_same_release: out_valid got %b expected %b", out_valid, SB);
    end
    tick();
    drain_scoreboard();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hF1F1);
    tick();
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hF2F2);
    tick();
    in_instr = mk(2'b11, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'hF3F3);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    nCompared++;
    if ({out_valid, in_ready, immediate} !== {2'b01, 16'h0000}) begin
      nMismatched++; $display("[TB] FAIL rst_mid: ov %b ir %b imm %h expected 0 1 0000", out_valid, in_ready, immediate);
    end
    out_ready = 1'b1;
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL rst_mid_drop: out_valid got %b expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_hazard();
    test_wb_same_cycle();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
